lsu_mem_initiator: RTL and testbench

- Load/store unit front end. Sits between the core's MEM stage and the 5-stage-pipelined data memory.
- Accepts one load/store from the core and checks alignment and funct3. Converts the access into the memory's one-cycle request pulse (we/wstrb/wstrb_load/addr/data), waits for mem_valid_out, and returns load data or store completion to the core.
- Allows exactly one outstanding access. This guarantees a store's delayed write has landed before any following load samples the array.

---
 rtl/lsu_mem_initiator_if.sv | 40 ++++
 rtl/lsu_mem_initiator.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response and data-memory bus of the load/store unit front end.
// The unit itself connects through the slave modport; the core/memory environment uses master.
interface lsu_mem_initiator_if;
    // Core request: an access transfers on a clock edge where req_valid && req_ready.
    // The core holds req_valid and req_* stable until that edge. resp_valid is a
    // one-cycle pulse with no back-pressure.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [3:0]  mem_wstrb_load;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_rdata, mem_valid,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err, busy,
        output mem_addr, mem_wdata, mem_we, mem_wstrb, mem_wstrb_load
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_rdata, mem_valid,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err, busy,
        input  mem_addr, mem_wdata, mem_we, mem_wstrb, mem_wstrb_load
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store front end: validates one core access, emits a single-cycle memory request,
// waits for the pipelined memory's valid (or a timeout) and returns a one-cycle response.
module lsu_mem_initiator #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_mem_initiator_if.slave   bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic        we_q, we_nx;
    logic [3:0]  strb_q, strb_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [4:0]  rd_q, rd_nx;
    logic [31:0] rdata_nx;
    logic [1:0]  err_nx;

    logic [3:0]  dec_strb;
    logic        dec_ill;
    logic        dec_mis;

    assign state_dbg = state;

    // Loads carry the extension mode in wstrb_load bit 3 (1 = zero-extend).
    always_comb begin
        dec_strb = 4'b0000;
        dec_ill  = 1'b0;
        dec_mis  = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'b000:  dec_strb = 4'b0001;
                3'b001:  dec_strb = 4'b0011;
                3'b010:  dec_strb = 4'b1111;
                default: dec_ill  = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000:  dec_strb = 4'b0001;
                3'b001:  dec_strb = 4'b0011;
                3'b010:  dec_strb = 4'b1111;
                3'b100:  dec_strb = 4'b1001;
                3'b101:  dec_strb = 4'b1011;
                default: dec_ill  = 1'b1;
            endcase
        end
        case (bus.req_funct3[1:0])
            2'b01:   dec_mis = bus.req_addr[0];
            2'b10:   dec_mis = |bus.req_addr[1:0];
            default: dec_mis = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we_nx    = we_q;
        strb_nx  = strb_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        rd_nx    = rd_q;
        rdata_nx = 32'h0;
        err_nx   = 2'b00;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    we_nx    = bus.req_we;
                    strb_nx  = dec_strb;
                    addr_nx  = bus.req_addr;
                    wdata_nx = bus.req_wdata;
                    rd_nx    = bus.req_rd;
                    if (dec_ill) begin
                        err_nx   = 2'b10;
                        state_nx = ERR;
                    end else if (dec_mis) begin
                        err_nx   = 2'b01;
                        state_nx = ERR;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt + CNT_W'(1);
                // A valid arriving on the timeout cycle still completes normally.
                if (bus.mem_valid) begin
                    rdata_nx = we_q ? 32'h0 : bus.mem_rdata;
                    state_nx = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nx   = 2'b11;
                    state_nx = RESP;
                end
            end
            RESP, ERR: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            we_q               <= 1'b0;
            strb_q             <= 4'b0000;
            addr_q             <= 32'h0;
            wdata_q            <= 32'h0;
            rd_q               <= 5'd0;
            bus.req_ready      <= 1'b1;
            bus.busy           <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= 32'h0;
            bus.resp_rd        <= 5'd0;
            bus.resp_err       <= 2'b00;
            bus.mem_addr       <= 32'h0;
            bus.mem_wdata      <= 32'h0;
            bus.mem_we         <= 1'b0;
            bus.mem_wstrb      <= 4'b0000;
            bus.mem_wstrb_load <= 4'b0000;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            we_q           <= we_nx;
            strb_q         <= strb_nx;
            addr_q         <= addr_nx;
            wdata_q        <= wdata_nx;
            rd_q           <= rd_nx;
            bus.req_ready  <= (state_nx == IDLE);
            bus.busy       <= (state_nx != IDLE);
            if (state_nx == RESP || state_nx == ERR) begin
                bus.resp_valid <= 1'b1;
                bus.resp_rdata <= rdata_nx;
                bus.resp_rd    <= rd_nx;
                bus.resp_err   <= err_nx;
            end else begin
                bus.resp_valid <= 1'b0;
                bus.resp_rdata <= 32'h0;
                bus.resp_rd    <= 5'd0;
                bus.resp_err   <= 2'b00;
            end
            // The memory treats any nonzero we/wstrb_load as a request, so these stay
            // quiet outside the single ISSUE cycle.
            if (state_nx == ISSUE) begin
                bus.mem_addr       <= addr_nx;
                bus.mem_wdata      <= we_nx ? wdata_nx : 32'h0;
                bus.mem_we         <= we_nx;
                bus.mem_wstrb      <= we_nx ? strb_nx : 4'b0000;
                bus.mem_wstrb_load <= we_nx ? 4'b0000 : strb_nx;
            end else begin
                bus.mem_addr       <= 32'h0;
                bus.mem_wdata      <= 32'h0;
                bus.mem_we         <= 1'b0;
                bus.mem_wstrb      <= 4'b0000;
                bus.mem_wstrb_load <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 6-edge-latency data memory model.
module tb_lsu_mem_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    lsu_mem_initiator_if bus ();

    lsu_mem_initiator #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: request seen in cycle I produces mem_valid in cycle I+6.
    typedef struct packed {
        logic        v;
        logic        we;
        logic [3:0]  ws;
        logic [3:0]  wl;
        logic [31:0] a;
        logic [31:0] d;
    } mreq_t;

    mreq_t       pipe [0:6];
    logic [31:0] mem_arr [0:255];
    logic        mem_dead = 1'b0;
    logic        inject = 1'b0;
    int          we_cycles = 0;
    int          ld_cycles = 0;
    logic [3:0]  last_ws = 4'h0;
    logic [3:0]  last_wl = 4'h0;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        for (int i = 0; i < 7; i++) pipe[i] = '0;
    end

    always @(negedge clk) begin
        logic [31:0] w;
        logic [1:0]  lane;
        logic [7:0]  idx;
        mreq_t       r;
        for (int i = 6; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0].v  = bus.mem_we || (bus.mem_wstrb_load != 4'b0000);
        pipe[0].we = bus.mem_we;
        pipe[0].ws = bus.mem_wstrb;
        pipe[0].wl = bus.mem_wstrb_load;
        pipe[0].a  = bus.mem_addr;
        pipe[0].d  = bus.mem_wdata;
        if (bus.mem_we) begin we_cycles++; last_ws = bus.mem_wstrb; end
        if (bus.mem_wstrb_load != 4'b0000) begin ld_cycles++; last_wl = bus.mem_wstrb_load; end
        bus.mem_valid = inject;
        bus.mem_rdata = inject ? 32'h1234_5678 : 32'h0;
        r = pipe[6];
        if (r.v && !mem_dead) begin
            lane = r.a[1:0];
            idx  = r.a[9:2];
            bus.mem_valid = 1'b1;
            if (r.we) begin
                for (int b = 0; b < 4; b++)
                    if (r.ws[b] && (b + int'(lane)) < 4)
                        mem_arr[idx][8*(b+int'(lane)) +: 8] = r.d[8*b +: 8];
            end else begin
                w = mem_arr[idx] >> {lane, 3'b000};
                case (r.wl)
                    4'b0001: bus.mem_rdata = {{24{w[7]}}, w[7:0]};
                    4'b0011: bus.mem_rdata = {{16{w[15]}}, w[15:0]};
                    4'b1111: bus.mem_rdata = w;
                    4'b1001: bus.mem_rdata = {24'h0, w[7:0]};
                    4'b1011: bus.mem_rdata = {16'h0, w[15:0]};
                    default: bus.mem_rdata = 32'h0;
                endcase
            end
        end
    end

    logic [31:0] r_data;
    logic [4:0]  r_rd;
    logic [1:0]  r_err;
    int          r_lat;

    // Latency is the cycle index after the accept edge in which resp_valid is seen (cycle A+n).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] rd);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        check("ready_wait", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        we_cycles = 0; ld_cycles = 0; last_ws = 4'h0; last_wl = 4'h0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        r_lat = 1;
        while (!bus.resp_valid && r_lat < 40) begin @(posedge clk); #1; r_lat++; end
        r_data = bus.resp_rdata;
        r_rd   = bus.resp_rd;
        r_err  = bus.resp_err;
        check("resp_seen", {31'h0, bus.resp_valid}, 32'h1);
    endtask

    task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [1:0] exp_err);
        do_access(we, f3, addr, 32'hCAFE_F00D, 5'd17);
        check({tag, "_err"}, r_err, exp_err);
        check({tag, "_lat"}, r_lat, 1);
        check({tag, "_rdata"}, r_data, 32'h0);
        check({tag, "_rd"}, r_rd, 5'd17);
        check({tag, "_busq"}, we_cycles + ld_cycles, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.req_ready, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_rvalid"}, bus.resp_valid, 1'b0);
        check({tag, "_rerr"}, bus.resp_err, 2'b00);
        check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
        check({tag, "_rrd"}, bus.resp_rd, 5'd0);
        check({tag, "_maddr"}, bus.mem_addr, 32'h0);
        check({tag, "_mwdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_mwe"}, bus.mem_we, 1'b0);
        check({tag, "_mws"}, bus.mem_wstrb, 4'h0);
        check({tag, "_mwl"}, bus.mem_wstrb_load, 4'h0);
        check({tag, "_state"}, state_dbg, 3'd0);
    endtask

    initial begin
        int first_k, second_k, ready_k, issue2_k, resp_hits, not_ready;
        logic [31:0] sec_data;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Word store then load back.
        do_access(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd3);
        check("sw_lat", r_lat, 8);
        check("sw_err", r_err, 2'b00);
        check("sw_rdata", r_data, 32'h0);
        check("sw_rd", r_rd, 5'd3);
        check("sw_we_cycles", we_cycles, 1);
        check("sw_wstrb", last_ws, 4'b1111);
        check("sw_ld_cycles", ld_cycles, 0);
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 5'd4);
        check("lw_lat", r_lat, 8);
        check("lw_rdata", r_data, 32'hDEAD_BEEF);
        check("lw_rd", r_rd, 5'd4);
        check("lw_ld_cycles", ld_cycles, 1);
        check("lw_wstrb_load", last_wl, 4'b1111);
        check("lw_we_cycles", we_cycles, 0);

        // Byte and halfword encodings.
        do_access(1'b1, 3'b000, 32'h80, 32'h0000_00A5, 5'd5);
        check("sb_err", r_err, 2'b00);
        check("sb_wstrb", last_ws, 4'b0001);
        do_access(1'b0, 3'b000, 32'h80, 32'h0, 5'd6);
        check("lb_rdata", r_data, 32'hFFFF_FFA5);
        check("lb_wstrb_load", last_wl, 4'b0001);
        check("lb_rd", r_rd, 5'd6);
        do_access(1'b0, 3'b100, 32'h80, 32'h0, 5'd7);
        check("lbu_rdata", r_data, 32'h0000_00A5);
        check("lbu_wstrb_load", last_wl, 4'b1001);
        check("lbu_rd", r_rd, 5'd7);
        do_access(1'b1, 3'b001, 32'h84, 32'h0000_8001, 5'd10);
        check("sh_wstrb", last_ws, 4'b0011);
        do_access(1'b0, 3'b001, 32'h84, 32'h0, 5'd11);
        check("lh_rdata", r_data, 32'hFFFF_8001);
        check("lh_wstrb_load", last_wl, 4'b0011);
        do_access(1'b0, 3'b101, 32'h84, 32'h0, 5'd12);
        check("lhu_rdata", r_data, 32'h0000_8001);
        check("lhu_wstrb_load", last_wl, 4'b1011);

        // Early errors; illegal funct3 beats misalignment.
        err_case("lw_mis", 1'b0, 3'b010, 32'h42, 2'b01);
        err_case("sh_mis", 1'b1, 3'b001, 32'h41, 2'b01);
        err_case("ld_f011", 1'b0, 3'b011, 32'h40, 2'b10);
        err_case("st_f011_mis", 1'b1, 3'b011, 32'h41, 2'b10);
        err_case("ld_f110_mis", 1'b0, 3'b110, 32'h43, 2'b10);
        err_case("st_f100", 1'b1, 3'b100, 32'h40, 2'b10);

        // Silent memory: timeout after 15 cycles in WAIT.
        mem_dead = 1'b1;
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 5'd13);
        check("to_lat", r_lat, 17);
        check("to_err", r_err, 2'b11);
        check("to_rdata", r_data, 32'h0);
        check("to_rd", r_rd, 5'd13);
        @(posedge clk); #1;
        check("to_ready", bus.req_ready, 1'b1);
        check("to_state", state_dbg, 3'd0);
        repeat (10) @(posedge clk);
        #1;
        mem_dead = 1'b0;

        // Quiet idle bus, then back-to-back with req_valid held.
        we_cycles = 0; ld_cycles = 0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_we", we_cycles, 0);
        check("idle_ld", ld_cycles, 0);
        check("idle_busy", bus.busy, 1'b0);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h40; bus.req_rd = 5'd8;
        we_cycles = 0; ld_cycles = 0;
        first_k = 0; second_k = 0; ready_k = 0; issue2_k = 0; sec_data = 32'h0;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            if (bus.resp_valid) begin
                if (first_k == 0) first_k = k;
                else begin second_k = k; sec_data = bus.resp_rdata; end
            end
            if (bus.req_ready && ready_k == 0) ready_k = k;
            if (bus.mem_wstrb_load != 4'h0 && k > 1 && issue2_k == 0) issue2_k = k;
            if (second_k != 0) break;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        check("b2b_first_resp", first_k, 8);
        check("b2b_ready", ready_k, 9);
        check("b2b_issue2", issue2_k, 10);
        check("b2b_second_resp", second_k, 17);
        check("b2b_second_data", sec_data, 32'hDEAD_BEEF);
        check("b2b_ld_cycles", ld_cycles, 2);
        check("b2b_we_cycles", we_cycles, 0);

        // Reset in WAIT; a late valid afterwards must be ignored.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h40; bus.req_rd = 5'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rw_state_wait", state_dbg, 3'd2);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_hits = 0; not_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            inject = (k == 2);
            resp_hits += int'(bus.resp_valid);
            not_ready += int'(!bus.req_ready);
        end
        inject = 1'b0;
        check("rw_resp_hits", resp_hits, 0);
        check("rw_not_ready", not_ready, 0);
        check_reset_outputs("rw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
